// File: rtl/spi_rx_buffer.sv
// rtl/spi_rx_buffer.sv - SPI mode-0 slave: gathers bytes of a cs_n frame into a register buffer and shifts tx out on MISO.
// All SPI pins are oversampled in sys_clk; only synchronised edges drive the state.
module spi_rx_buffer #(
   parameter int BYTES = 4,
   parameter int CNT_W = 3
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic               spi_sclk,
   input  logic               spi_cs_n,
   input  logic               spi_rx,
   output logic               spi_tx,
   input  logic [7:0]         tx,
   output logic [BYTES*8-1:0] rx,
   output logic [CNT_W-1:0]   rx_count,
   output logic               rx_valid
);

   logic               sclk_meta_q, sclk_meta_d;
   logic               sclk_sync_q, sclk_sync_d;
   logic               sclk_prev_q, sclk_prev_d;
   logic               cs_meta_q, cs_meta_d;
   logic               cs_sync_q, cs_sync_d;
   logic               cs_prev_q, cs_prev_d;
   logic               mosi_meta_q, mosi_meta_d;
   logic               mosi_sync_q, mosi_sync_d;
   logic               frame_active_q, frame_active_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         rx_shift_q, rx_shift_d;
   logic [7:0]         tx_shift_q, tx_shift_d;
   logic [BYTES*8-1:0] rx_q, rx_d;
   logic [CNT_W-1:0]   rx_count_q, rx_count_d;
   logic               rx_valid_q, rx_valid_d;
   logic               spi_tx_q, spi_tx_d;

   logic               sclk_rise, sclk_fall;
   logic               cs_fall, cs_rise;
   logic [7:0]         rx_byte;

   // Synchronisers reset low so that a cs_n already held low at reset release
   // never looks like a falling edge; a fresh frame start is required.
   assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
   assign cs_fall   = ~cs_sync_q & cs_prev_q;
   assign cs_rise   = cs_sync_q & ~cs_prev_q;
   assign rx_byte   = {rx_shift_q[6:0], mosi_sync_q};

   always_comb begin
      sclk_meta_d    = spi_sclk;
      sclk_sync_d    = sclk_meta_q;
      sclk_prev_d    = sclk_sync_q;
      cs_meta_d      = spi_cs_n;
      cs_sync_d      = cs_meta_q;
      cs_prev_d      = cs_sync_q;
      mosi_meta_d    = spi_rx;
      mosi_sync_d    = mosi_meta_q;
      frame_active_d = frame_active_q;
      bit_cnt_d      = bit_cnt_q;
      rx_shift_d     = rx_shift_q;
      tx_shift_d     = tx_shift_q;
      rx_d           = rx_q;
      rx_count_d     = rx_count_q;
      rx_valid_d     = 1'b0;

      // cs_n rising takes priority over any sclk edge seen in the same cycle.
      if (cs_rise) begin
         frame_active_d = 1'b0;
         bit_cnt_d      = 3'd0;
         rx_shift_d     = 8'd0;
      end else if (cs_fall) begin
         frame_active_d = 1'b1;
         bit_cnt_d      = 3'd0;
         rx_shift_d     = 8'd0;
         rx_count_d     = '0;
         tx_shift_d     = tx;
      end else if (frame_active_q) begin
         if (sclk_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && rx_count_q < CNT_W'(BYTES)) begin
               for (int i = 0; i < BYTES; i++) begin
                  if (CNT_W'(i) == rx_count_q) begin
                     rx_d[8*i +: 8] = rx_byte;
                  end
               end
               rx_count_d = rx_count_q + CNT_W'(1);
               rx_valid_d = 1'b1;
            end
         end else if (sclk_fall) begin
            // bit_cnt wrapped to 0 means the falling edge after a byte's last bit.
            if (bit_cnt_q == 3'd0) begin
               tx_shift_d = tx;
            end else begin
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
      end

      spi_tx_d = frame_active_d & tx_shift_d[7];
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         sclk_meta_q    <= 1'b0;
         sclk_sync_q    <= 1'b0;
         sclk_prev_q    <= 1'b0;
         cs_meta_q      <= 1'b0;
         cs_sync_q      <= 1'b0;
         cs_prev_q      <= 1'b0;
         mosi_meta_q    <= 1'b0;
         mosi_sync_q    <= 1'b0;
         frame_active_q <= 1'b0;
         bit_cnt_q      <= 3'd0;
         rx_shift_q     <= 8'd0;
         tx_shift_q     <= 8'd0;
         rx_q           <= '0;
         rx_count_q     <= '0;
         rx_valid_q     <= 1'b0;
         spi_tx_q       <= 1'b0;
      end else begin
         sclk_meta_q    <= sclk_meta_d;
         sclk_sync_q    <= sclk_sync_d;
         sclk_prev_q    <= sclk_prev_d;
         cs_meta_q      <= cs_meta_d;
         cs_sync_q      <= cs_sync_d;
         cs_prev_q      <= cs_prev_d;
         mosi_meta_q    <= mosi_meta_d;
         mosi_sync_q    <= mosi_sync_d;
         frame_active_q <= frame_active_d;
         bit_cnt_q      <= bit_cnt_d;
         rx_shift_q     <= rx_shift_d;
         tx_shift_q     <= tx_shift_d;
         rx_q           <= rx_d;
         rx_count_q     <= rx_count_d;
         rx_valid_q     <= rx_valid_d;
         spi_tx_q       <= spi_tx_d;
      end
   end

   assign spi_tx   = spi_tx_q;
   assign rx       = rx_q;
   assign rx_count = rx_count_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// tb/tb_spi_rx_buffer.sv - scoreboard bench for spi_rx_buffer.
module tb_spi_rx_buffer;

   localparam int BYTES = 4;
   localparam int CNT_W = 3;
   localparam int HALF  = 8;

   logic               sys_clk = 1'b0;
   logic               reset = 1'b0;
   logic               spi_sclk = 1'b0;
   logic               spi_cs_n = 1'b1;
   logic               spi_rx = 1'b0;
   logic               spi_tx;
   logic [7:0]         tx = 8'h00;
   logic [BYTES*8-1:0] rx;
   logic [CNT_W-1:0]   rx_count;
   logic               rx_valid;

   typedef struct {
      int         idx;
      logic [7:0] data;
      int         cnt;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_pass = 0;
   int         n_valid = 0;
   int         model_cnt = 0;
   logic [7:0] model_rx[BYTES];
   logic       model_active = 1'b0;
   logic [7:0] miso_byte;

   spi_rx_buffer #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .spi_sclk(spi_sclk),
      .spi_cs_n(spi_cs_n),
      .spi_rx  (spi_rx),
      .spi_tx  (spi_tx),
      .tx      (tx),
      .rx      (rx),
      .rx_count(rx_count),
      .rx_valid(rx_valid)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   always @(negedge sys_clk) begin
      if (reset === 1'b1 && rx_valid === 1'b1) begin
         n_valid++;
         if (sb.size() == 0) begin
            check_eq("unexpected_rx_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq($sformatf("sb_byte%0d", e.idx), 32'(rx[8*e.idx +: 8]), 32'(e.data));
            check_eq($sformatf("sb_count%0d", e.idx), 32'(rx_count), 32'(e.cnt));
         end
      end
   end

   task automatic send_bits(input logic [7:0] v, input int n);
      if (n == 8 && model_active && model_cnt < BYTES) begin
         sb.push_back('{idx: model_cnt, data: v, cnt: model_cnt + 1});
         model_rx[model_cnt] = v;
         model_cnt++;
      end
      for (int i = 7; i > 7 - n; i--) begin
         spi_rx = v[i];
         wait_clks(HALF);
         spi_sclk = 1'b1;
         miso_byte[i] = spi_tx;
         wait_clks(HALF);
         spi_sclk = 1'b0;
      end
      wait_clks(HALF);
      check_eq("sb_drain", sb.size(), 32'd0);
   endtask

   task automatic frame_begin();
      spi_cs_n = 1'b0;
      model_active = 1'b1;
      model_cnt = 0;
      wait_clks(10);
   endtask

   task automatic frame_end();
      wait_clks(4);
      spi_cs_n = 1'b1;
      model_active = 1'b0;
      wait_clks(10);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      model_active = 1'b0;
      model_cnt = 0;
      for (int i = 0; i < BYTES; i++) model_rx[i] = 8'h00;
      wait_clks(3);
      check_eq({tag, "_rx"}, rx, 32'd0);
      check_eq({tag, "_count"}, 32'(rx_count), 32'd0);
      check_eq({tag, "_valid"}, 32'(rx_valid), 32'd0);
      check_eq({tag, "_spi_tx"}, 32'(spi_tx), 32'd0);
      reset = 1'b1;
      wait_clks(5);
   endtask

   task automatic check_buffer(input string tag);
      check_eq({tag, "_count"}, 32'(rx_count), 32'(model_cnt));
      for (int i = 0; i < BYTES; i++)
         check_eq($sformatf("%s_byte%0d", tag, i), 32'(rx[8*i +: 8]), 32'(model_rx[i]));
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      frame_begin();
      send_bits(b0, 8);
      send_bits(b1, 8);
      send_bits(b2, 8);
      send_bits(b3, 8);
      frame_end();
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      for (int i = 0; i < BYTES; i++) model_rx[i] = 8'h00;
      wait_clks(2);
      do_reset("reset0");

      v0 = n_valid;
      send_frame(8'hAA, 8'h55, 8'hCC, 8'h33);
      check_buffer("f_aa55");
      check_eq("f_aa55_pulses", n_valid - v0, 32'd4);

      do_reset("reset1");
      send_frame(8'h0F, 8'hF0, 8'h00, 8'hFF);
      check_buffer("f_0ff0");

      frame_begin();
      send_bits(8'h01, 8);
      check_buffer("f_01_first");
      send_bits(8'h02, 8);
      send_bits(8'h03, 8);
      send_bits(8'h04, 8);
      frame_end();
      check_buffer("f_01_all");

      v0 = n_valid;
      frame_begin();
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      send_bits(8'h33, 8);
      send_bits(8'h44, 8);
      send_bits(8'h55, 8);
      frame_end();
      check_buffer("f_sat");
      check_eq("f_sat_byte3", 32'(rx[31:24]), 32'h44);
      check_eq("f_sat_pulses", n_valid - v0, 32'd4);

      frame_begin();
      send_bits(8'hA1, 8);
      send_bits(8'hE7, 5);
      frame_end();
      check_buffer("f_partial");
      frame_begin();
      send_bits(8'hB2, 8);
      frame_end();
      check_buffer("f_restart");
      check_eq("f_restart_byte0", 32'(rx[7:0]), 32'hB2);

      frame_begin();
      send_bits(8'h96, 3);
      do_reset("reset_mid");
      send_bits(8'hC3, 8);
      check_buffer("after_reset_no_frame");
      frame_end();

      tx = 8'hA5;
      frame_begin();
      send_bits(8'h3C, 8);
      check_eq("miso_byte0", 32'(miso_byte), 32'hA5);
      send_bits(8'h81, 8);
      check_eq("miso_byte1", 32'(miso_byte), 32'hA5);
      frame_end();
      check_buffer("f_tx");
      check_eq("f_tx_byte0", 32'(rx[7:0]), 32'h3C);
      check_eq("idle_spi_tx", 32'(spi_tx), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
